// File: rtl/op_issue_queue_pkg.sv
// OpTypes: shared decode/issue types used by the issue queue and its bench.
// The queue depth default lives here so front-end and back-end agree on it.
package OpTypes;

  localparam int ISSUE_QUEUE_DEPTH = 4;

  // Decoded operation summary; isBubble marks a slot decode filled with nothing.
  typedef struct packed {
    logic       isBubble;
    logic [3:0] fuType;
    logic [7:0] opcode;
  } OpInfo;

  // One issue-queue slot: op summary, fetch PC and architectural registers.
  typedef struct packed {
    OpInfo       opInfo;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } IssueQueueEntry;

endpackage

// File: rtl/op_issue_queue_ram.sv
// op_issue_queue_ram: DEPTH x W register array, one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module op_issue_queue_ram #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed slot on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Head read is combinational so the consumer sees the entry without a bubble.
  assign rdata = mem[raddr];

endmodule

// File: rtl/op_issue_queue.sv
// op_issue_queue: FIFO of decoded instructions between decode and issue.
// Bubble ops are consumed without being stored, flush empties the queue,
// and count/full/empty let the front end throttle.
// Handshake: a side transfers on a rising edge where its valid and ready are
// both 1 and flush is 0; enqReady = !full and never looks at deqReady.
// Optional macro OP_ISSUE_QUEUE_BYPASS_EN: when empty, a non-bubble enqueue is
// presented at the head in the same cycle and, if taken, is never stored.
// stateDbg exposes the control FSM: 0 = EMPTY, 1 = PARTIAL, 2 = FULL.
module op_issue_queue
  import OpTypes::*;
#(
  parameter  int DEPTH = ISSUE_QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic                              flush,
  input  logic                              enqValid,
  input  logic [$bits(IssueQueueEntry)-1:0] enqEntry,
  output logic                              enqReady,
  output logic                              deqValid,
  output logic [$bits(IssueQueueEntry)-1:0] deqEntry,
  input  logic                              deqReady,
  output logic [CNT_W-1:0]                  count,
  output logic                              full,
  output logic                              empty,
  output logic [1:0]                        stateDbg
);

  localparam logic [1:0] S_EMPTY   = 2'd0;
  localparam logic [1:0] S_PARTIAL = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  IssueQueueEntry   enqE;
  IssueQueueEntry   ramRdata;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] nextCount;
  logic [1:0]       state;
  logic [1:0]       nextState;
  logic             enqFire;
  logic             deqFire;
  logic             bypass;
  logic             doWrite;
  logic             doRead;

  assign enqE     = enqEntry;
  assign full     = (count == DEPTH_CNT);
  assign empty    = (count == '0);
  assign enqReady = !full;
  assign stateDbg = state;

`ifdef OP_ISSUE_QUEUE_BYPASS_EN
  assign bypass   = empty && enqValid && !enqE.opInfo.isBubble && !flush;
  assign deqValid = !empty || bypass;
  assign deqEntry = bypass ? enqE : ramRdata;
`else
  assign bypass   = 1'b0;
  assign deqValid = !empty;
  assign deqEntry = ramRdata;
`endif

  assign enqFire = enqValid && enqReady && !flush;
  assign deqFire = deqValid && deqReady && !flush;
  // A bubble is accepted but never stored; a bypassed entry taken this cycle
  // goes straight to issue and touches neither the array nor the pointers.
  assign doWrite = enqFire && !enqE.opInfo.isBubble && !(bypass && deqReady);
  assign doRead  = deqFire && !bypass;

  op_issue_queue_ram #(
    .DEPTH (DEPTH),
    .W     ($bits(IssueQueueEntry))
  ) u_ram (
    .clk   (clk),
    .we    (doWrite),
    .waddr (tail),
    .wdata (enqE),
    .raddr (head),
    .rdata (ramRdata)
  );

  // Occupancy after this edge; flush overrides any simultaneous transfer.
  always_comb begin
    nextCount = count;
    if (flush) begin
      nextCount = '0;
    end else if (doWrite && !doRead) begin
      nextCount = count + CNT_W'(1);
    end else if (doRead && !doWrite) begin
      nextCount = count - CNT_W'(1);
    end
  end

  // Control FSM transitions follow the occupancy the queue is about to hold.
  always_comb begin
    nextState = state;
    case (state)
      S_EMPTY:   if (nextCount != '0) nextState = S_PARTIAL;
      S_PARTIAL: begin
        if (nextCount == DEPTH_CNT) nextState = S_FULL;
        else if (nextCount == '0)   nextState = S_EMPTY;
      end
      S_FULL:    if (nextCount != DEPTH_CNT) nextState = S_PARTIAL;
      default:   nextState = S_EMPTY;
    endcase
    if (flush) nextState = S_EMPTY;
  end

  // Pointers, occupancy and FSM state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= S_EMPTY;
    end else begin
      count <= nextCount;
      state <= nextState;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (doWrite) tail <= tail + PTR_W'(1);
        if (doRead)  head <= head + PTR_W'(1);
      end
    end
  end

`ifndef SYNTHESIS
  aCountMax:   assert property (@(posedge clk) disable iff (!rstN) count <= DEPTH_CNT);
  aNoEnqFull:  assert property (@(posedge clk) disable iff (!rstN) !(enqFire && full));
  aNoDeqEmpty: assert property (@(posedge clk) disable iff (!rstN) !(doRead && empty));
`endif

endmodule

// File: tb/tb_op_issue_queue.sv
// Bench for op_issue_queue: directed scenarios plus random traffic, every
// cycle compared against a queue-based model of the issue queue.
module tb_op_issue_queue;
  import OpTypes::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             flush = 1'b0;
  logic             enqValid = 1'b0;
  logic             deqReady = 1'b0;
  IssueQueueEntry   enqEntry = '0;
  IssueQueueEntry   deqEntry;
  logic             enqReady;
  logic             deqValid;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic [1:0]       stateDbg;

  IssueQueueEntry   exp_q[$];
  int               vectors = 0;
  int               miscompares = 0;

  // Clock / reset
  always #5 clk = ~clk;

  op_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .flush    (flush),
    .enqValid (enqValid),
    .enqEntry (enqEntry),
    .enqReady (enqReady),
    .deqValid (deqValid),
    .deqEntry (deqEntry),
    .deqReady (deqReady),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .stateDbg (stateDbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic IssueQueueEntry mkEntry(input logic [31:0] pc, input logic bubble);
    IssueQueueEntry e;
    e.opInfo.isBubble = bubble;
    e.opInfo.fuType   = 4'($urandom_range(0, 15));
    e.opInfo.opcode   = 8'($urandom_range(0, 255));
    e.pc              = pc;
    e.rs1             = 5'($urandom_range(0, 31));
    e.rs2             = 5'($urandom_range(0, 31));
    e.rd              = 5'($urandom_range(0, 31));
    return e;
  endfunction

  // Same-cycle delivery of an incoming entry into an empty queue.
  function automatic logic modelBypass();
`ifdef OP_ISSUE_QUEUE_BYPASS_EN
    return (exp_q.size() == 0) && enqValid && !enqEntry.opInfo.isBubble && !flush;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard compare: outputs derived from the model's occupancy and head.
  task automatic checkOutputs();
    int   n;
    logic bp;
    n  = exp_q.size();
    bp = modelBypass();
    chk("count",    64'(count),    64'(n));
    chk("full",     64'(full),     64'(n == DEPTH));
    chk("empty",    64'(empty),    64'(n == 0));
    chk("enqReady", 64'(enqReady), 64'(n < DEPTH));
    chk("deqValid", 64'(deqValid), 64'((n > 0) || bp));
    chk("state",    64'(stateDbg), 64'((n == 0) ? 0 : (n == DEPTH) ? 2 : 1));
    if (n > 0)   chk("deqEntry", 64'(deqEntry), 64'(exp_q[0]));
    else if (bp) chk("bypassEntry", 64'(deqEntry), 64'(enqEntry));
  endtask

  // Model transition for the edge that ends the current cycle.
  task automatic modelStep();
    int   n;
    logic bp;
    logic deq;
    logic enq;
    n   = exp_q.size();
    bp  = modelBypass();
    deq = ((n > 0) || bp) && deqReady;
    enq = enqValid && (n < DEPTH);
    if (flush) begin
      exp_q.delete();
    end else if (bp) begin
      if (!deqReady) exp_q.push_back(enqEntry);
    end else begin
      if (deq) void'(exp_q.pop_front());
      if (enq && !enqEntry.opInfo.isBubble) exp_q.push_back(enqEntry);
    end
  endtask

  // Driver: inputs change just after the falling edge, outputs compared 1 time
  // unit later, model advances with the following rising edge.
  task automatic drive(input logic ev, input IssueQueueEntry e, input logic dr, input logic fl);
    @(negedge clk);
    enqValid = ev;
    enqEntry = e;
    deqReady = dr;
    flush    = fl;
    #1;
    checkOutputs();
  endtask

  task automatic finishCycle();
    modelStep();
    @(posedge clk);
  endtask

  task automatic cycle(input logic ev, input IssueQueueEntry e, input logic dr, input logic fl);
    drive(ev, e, dr, fl);
    finishCycle();
  endtask

  initial begin
    // Reset values while rstN is held low.
    #3;
    chk("rst_count",    64'(count),    64'd0);
    chk("rst_empty",    64'(empty),    64'd1);
    chk("rst_full",     64'(full),     64'd0);
    chk("rst_enqReady", 64'(enqReady), 64'd1);
    chk("rst_deqValid", 64'(deqValid), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Fill to DEPTH with the consumer stalled, then offer a fifth entry.
    for (int i = 0; i < 4; i++) cycle(1'b1, mkEntry(32'(4 * i), 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkEntry(32'h10, 1'b0), 1'b0, 1'b0);
    #1;
    chk("fill_count",    64'(count),       64'd4);
    chk("fill_full",     64'(full),        64'd1);
    chk("fill_enqReady", 64'(enqReady),    64'd0);
    chk("fill_headpc",   64'(deqEntry.pc), 64'h0);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      #1;
      if (i < 3) chk("drain_pc", 64'(deqEntry.pc), 64'(4 * (i + 1)));
    end
    chk("drain_empty",    64'(empty),    64'd1);
    chk("drain_deqValid", 64'(deqValid), 64'd0);

    // Bubble is consumed but never stored.
    cycle(1'b1, mkEntry(32'h10, 1'b1), 1'b0, 1'b0);
    cycle(1'b1, mkEntry(32'h14, 1'b0), 1'b0, 1'b0);
    #1;
    chk("bubble_count", 64'(count),       64'd1);
    chk("bubble_pc",    64'(deqEntry.pc), 64'h14);

    // Streaming enqueue+dequeue across pointer wrap.
    for (int i = 0; i < 10; i++) cycle(1'b1, mkEntry(32'(4 * i), 1'b0), 1'b1, 1'b0);
    #1;
    chk("stream_count", 64'(count),       64'd1);
    chk("stream_pc",    64'(deqEntry.pc), 64'h24);

    // Flush beats a simultaneous enqueue and dequeue.
    cycle(1'b1, mkEntry(32'h50, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkEntry(32'h54, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkEntry(32'h58, 1'b0), 1'b1, 1'b1);
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_empty", 64'(empty), 64'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);

`ifdef OP_ISSUE_QUEUE_BYPASS_EN
    // Empty queue: entry delivered in the same cycle, nothing stored.
    drive(1'b1, mkEntry(32'h40, 1'b0), 1'b1, 1'b0);
    chk("byp_deqValid", 64'(deqValid),    64'd1);
    chk("byp_pc",       64'(deqEntry.pc), 64'h40);
    finishCycle();
    #1;
    chk("byp_count", 64'(count), 64'd0);
`endif

    // Asynchronous reset between edges with two entries held.
    cycle(1'b1, mkEntry(32'h60, 1'b0), 1'b0, 1'b0);
    cycle(1'b1, mkEntry(32'h64, 1'b0), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #1;
    rstN = 1'b0;
    #1;
    chk("arst_deqValid", 64'(deqValid), 64'd0);
    chk("arst_count",    64'(count),    64'd0);
    chk("arst_empty",    64'(empty),    64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("arst_hold_count", 64'(count), 64'd0);
    @(negedge clk);
    rstN = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            mkEntry($urandom, 1'($urandom_range(0, 3) == 0)),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 24) == 0));
    end

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
